// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A clk-to-pixel divider produces
//   one pixel tick every PIX_DIV clks. On each tick the raster counters h and v
//   advance, in the order active, front porch, sync, back porch. The fetch
//   coordinates follow the raster position directly. hs, vs, blank,
//   line_start and frame_start are decoded from the position delayed by LEAD
//   ticks. Framebuffer reads can therefore be issued ahead of display.
//
//   Optional feature macro: VGA_FRAME_COUNT_EN (adds frame_count, vblank_irq).
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous reset, active low
//   pix_en       out  one-clk pulse in the clk in which pixel outputs change
//   hs, vs       out  sync outputs, active level HS_POL / VS_POL
//   blank        out  high outside the active area
//   current_x    out  scaled x of the pixel to fetch (COORD_W)
//   current_y    out  scaled y of the pixel to fetch (COORD_W)
//   line_start   out  one-clk pulse at displayed h=0
//   frame_start  out  one-clk pulse at displayed h=0, v=0
//   frame_count  out  [15:0] frames started since reset   (VGA_FRAME_COUNT_EN)
//   vblank_irq   out  pulse when displayed v reaches V_ACTIVE (VGA_FRAME_COUNT_EN)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int PIX_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int LEAD        = 1,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               pix_en,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [COORD_W-1:0] current_x,
  output logic [COORD_W-1:0] current_y,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]        frame_count,
  output logic               vblank_irq
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = 12;
  localparam int V_W      = 11;
  localparam int DIV_W    = 4;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  // Ticks needed before the delayed position is a genuine advance rather
  // than a cleared pipeline entry or the reset position itself.
  localparam int FILL_MAX = LEAD + 1;
  localparam longint unsigned COORD_MAX = (64'd1 << COORD_W) - 64'd1;

  // Elaboration-time parameter checks
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV=%0d outside 1..16", PIX_DIV);
  end
  if (LEAD < 0 || LEAD > 3) begin : g_bad_lead
    $error("vga_timing_gen: LEAD=%0d outside 0..3", LEAD);
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_scale
    $error("vga_timing_gen: SCALE_SHIFT=%0d outside 0..3", SCALE_SHIFT);
  end
  if (H_TOTAL >= (1 << H_W) || V_TOTAL >= (1 << V_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d too large", H_TOTAL, V_TOTAL);
  end

  function automatic logic [COORD_W-1:0] sat_coord(input logic [H_W-1:0] val);
    if (64'(val) > COORD_MAX) return '1;
    return COORD_W'(val);
  endfunction

  // Divider and raster counters
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             tick_q;
  logic [H_W-1:0]   hcnt_q, hcnt_d;
  logic [V_W-1:0]   vcnt_q, vcnt_d;
  logic [2:0]       fill_q, fill_d;
  logic             filled;

  // Delayed (displayed) position
  logic [H_W-1:0]   hdly;
  logic [V_W-1:0]   vdly;

  // Output registers and their next values
  logic               pix_en_q;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  assign filled = (fill_q == 3'(FILL_MAX));

  always_comb begin
    tick   = (div_q == DIV_W'(PIX_DIV - 1));
    div_d  = tick ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    fill_d = fill_q;
    if (tick) begin
      if (hcnt_q == H_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_W'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
      if (!filled) fill_d = fill_q + 1'b1;
    end
  end

  // LEAD-deep position delay, advancing on tick. Entry 0 holds the position
  // one tick behind the live counters.
  if (LEAD == 0) begin : g_no_lead
    assign hdly = hcnt_q;
    assign vdly = vcnt_q;
  end else begin : g_lead
    logic [H_W-1:0] hpipe_q [LEAD];
    logic [V_W-1:0] vpipe_q [LEAD];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int i = 0; i < LEAD; i++) begin
          hpipe_q[i] <= '0;
          vpipe_q[i] <= '0;
        end
      end else if (tick) begin
        hpipe_q[0] <= hcnt_q;
        vpipe_q[0] <= vcnt_q;
        for (int i = 1; i < LEAD; i++) begin
          hpipe_q[i] <= hpipe_q[i-1];
          vpipe_q[i] <= vpipe_q[i-1];
        end
      end
    end

    assign hdly = hpipe_q[LEAD-1];
    assign vdly = vpipe_q[LEAD-1];
  end

  // Decode; sampled into the output registers one clk after the tick that
  // moved the counters, so coordinates and sync change in the same clk.
  always_comb begin
    x_d     = (hcnt_q < H_W'(H_ACTIVE)) ? sat_coord(hcnt_q >> SCALE_SHIFT) : '0;
    y_d     = (vcnt_q < V_W'(V_ACTIVE)) ? sat_coord({1'b0, vcnt_q >> SCALE_SHIFT}) : '0;
    blank_d = (hdly >= H_W'(H_ACTIVE)) || (vdly >= V_W'(V_ACTIVE));
    hs_d    = ((hdly >= H_W'(HS_START)) && (hdly < H_W'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d    = ((vdly >= V_W'(VS_START)) && (vdly < V_W'(VS_END))) ? VS_POL : ~VS_POL;
    ls_d    = filled && (hdly == '0);
    fs_d    = ls_d && (vdly == '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      fill_q   <= '0;
      tick_q   <= 1'b0;
      pix_en_q <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      blank_q  <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      fill_q   <= fill_d;
      tick_q   <= tick;
      pix_en_q <= tick_q;
      if (tick_q) begin
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        blank_q <= blank_d;
        x_q     <= x_d;
        y_q     <= y_d;
        ls_q    <= ls_d;
        fs_q    <= fs_d;
      end else begin
        ls_q    <= 1'b0;
        fs_q    <= 1'b0;
      end
    end
  end

  assign pix_en      = pix_en_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign current_x   = x_q;
  assign current_y   = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fcnt_q;
  logic        irq_q;

  // The count steps in the same edge that raises frame_start, so it already
  // shows the new frame number while frame_start is high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (tick_q && fs_d) fcnt_q <= fcnt_q + 1'b1;
      irq_q <= tick_q && (hdly == '0) && (vdly == V_W'(V_ACTIVE));
    end
  end

  assign frame_count = fcnt_q;
  assign vblank_irq  = irq_q;
`endif

endmodule
